// File: rtl/ex_hazard_if.sv
// ID/EX <-> hazard unit bundle: decoded ID fields in, forward selects / stall / flag select out.
// stall_count and PERF_W exist only when HAZARD_PERF_EN is defined.
interface ex_hazard_if #(
  parameter int REG_W = 5
`ifdef HAZARD_PERF_EN
  , parameter int PERF_W = 32
`endif
);
  logic             id_valid;
  logic [REG_W-1:0] id_rn;
  logic [REG_W-1:0] id_rm;
  logic             id_use_rn;
  logic             id_use_rm;
  logic [REG_W-1:0] id_rd;
  logic             id_regwrite;
  logic             id_memread;
  logic             id_setflags;
  logic             id_bcond;
  logic             flush;
  logic [1:0]       forwardA;
  logic [1:0]       forwardB;
  logic             stall;
  logic             flag_fwd;
`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_count;
`endif

  modport master (
    output id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd,
           id_regwrite, id_memread, id_setflags, id_bcond, flush,
    input  forwardA, forwardB, stall, flag_fwd
`ifdef HAZARD_PERF_EN
    , input stall_count
`endif
  );

  modport slave (
    input  id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd,
           id_regwrite, id_memread, id_setflags, id_bcond, flush,
    output forwardA, forwardB, stall, flag_fwd
`ifdef HAZARD_PERF_EN
    , output stall_count
`endif
  );
endinterface

// File: rtl/ex_hazard_unit.sv
// Execute-stage hazard controller: shadow EX/MEM/WB dest tracking, operand forwarding,
// load-use stall FSM and B.cond flag source. HAZARD_PERF_EN adds a saturating stall counter.
module ex_hazard_unit #(
  parameter int REG_W      = 5,
  parameter int ZERO_REG   = 31,
  parameter int LOAD_STALL = 2
`ifdef HAZARD_PERF_EN
  , parameter int PERF_W   = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  ex_hazard_if.slave hif
);
  typedef struct packed {
    logic [REG_W-1:0] rn, rm, rd;
    logic             use_rn, use_rm, rw, mr, sf;
  } ex_t;
  typedef struct packed { logic [REG_W-1:0] rd; logic rw, mr; } mem_t;
  typedef struct packed { logic [REG_W-1:0] rd; logic rw; } wb_t;
  typedef enum logic { IDLE, STALL } state_t;

  localparam logic [REG_W-1:0] ZR       = REG_W'(ZERO_REG);
  localparam logic [2:0]       CNT_INIT = 3'(LOAD_STALL - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  ex_t        ex_q, ex_d;
  mem_t       mem_q, mem_d;
  wb_t        wb_q, wb_d;
  logic       hazard, stall;

  // A load sitting in MEM has no data yet, so only non-load MEM results forward.
  function automatic logic [1:0] fwd_sel(input logic use_r, input logic [REG_W-1:0] r,
                                         input mem_t m, input wb_t w);
    fwd_sel = 2'b00;
    if (use_r && (r != ZR)) begin
      if (m.rw && !m.mr && (m.rd == r)) fwd_sel = 2'b01;
      else if (w.rw && (w.rd == r))     fwd_sel = 2'b10;
    end
  endfunction

  assign hazard = hif.id_valid & ex_q.mr & ex_q.rw & (ex_q.rd != ZR) &
                  ((hif.id_use_rn & (hif.id_rn == ex_q.rd)) |
                   (hif.id_use_rm & (hif.id_rm == ex_q.rd)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (hif.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (hazard && (LOAD_STALL > 1)) begin
          state_d = STALL;
          cnt_d   = CNT_INIT;
        end
        STALL: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stall = 1'b0;
    if (!hif.flush) begin
      case (state_q)
        IDLE:    stall = hazard;
        STALL:   stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  always_comb begin
    ex_d = '0;
    if (hif.id_valid && !stall && !hif.flush)
      ex_d = '{rn: hif.id_rn, rm: hif.id_rm, rd: hif.id_rd,
               use_rn: hif.id_use_rn, use_rm: hif.id_use_rm,
               rw: hif.id_regwrite, mr: hif.id_memread, sf: hif.id_setflags};
    mem_d = '{rd: ex_q.rd, rw: ex_q.rw, mr: ex_q.mr};
    wb_d  = '{rd: mem_q.rd, rw: mem_q.rw};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
    end
  end

  assign hif.forwardA = fwd_sel(ex_q.use_rn, ex_q.rn, mem_q, wb_q);
  assign hif.forwardB = fwd_sel(ex_q.use_rm, ex_q.rm, mem_q, wb_q);
  assign hif.stall    = stall;
  assign hif.flag_fwd = hif.id_valid & hif.id_bcond & ex_q.sf;

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) stall_count_d = stall_count_q + PERF_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_count_q <= '0;
    else       stall_count_q <= stall_count_d;
  end

  assign hif.stall_count = stall_count_q;
`endif
endmodule

// File: tb/tb_ex_hazard_unit.sv
// Bench for ex_hazard_unit: directed cycle table, reset-mid-stall sequence, then random
// stimulus against an in-flight instruction list reference model.
module tb_ex_hazard_unit;
  localparam int LS = 2;
  localparam int ZREG = 31;

  typedef struct {
    bit v, urn, urm, rw, mr, sf, bc;
    int rn, rm, rd;
  } instr_t;

  typedef struct {
    instr_t in;
    bit     fl;
    int     fa, fb;
    bit     st, ff;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  ex_hazard_if hif ();
  ex_hazard_unit #(.REG_W(5), .ZERO_REG(ZREG), .LOAD_STALL(LS)) dut (
    .clk(clk), .reset(reset), .hif(hif));

  always #5 clk = ~clk;

  // Reference model: list of instructions in EX(0), MEM(1), WB(2); stall budget in cycles.
  instr_t mp[3];
  int     m_left;
  int     m_perf;

  function automatic instr_t mk_i(bit v, int rn, int rm, bit urn, bit urm, int rd,
                                  bit rw, bit mr, bit sf, bit bc);
    instr_t i;
    i.v = v; i.rn = rn; i.rm = rm; i.urn = urn; i.urm = urm; i.rd = rd;
    i.rw = rw; i.mr = mr; i.sf = sf; i.bc = bc;
    return i;
  endfunction

  function automatic vec_t mk(bit v, int rn, int rm, bit urn, bit urm, int rd, bit rw,
                              bit mr, bit sf, bit bc, bit fl, int fa, int fb, bit st, bit ff);
    vec_t t;
    t.in = mk_i(v, rn, rm, urn, urm, rd, rw, mr, sf, bc);
    t.fl = fl; t.fa = fa; t.fb = fb; t.st = st; t.ff = ff;
    return t;
  endfunction

  function automatic int m_fwd(bit u, int r);
    if (!u || r == ZREG || !mp[0].v) return 0;
    if (mp[1].v && mp[1].rw && !mp[1].mr && mp[1].rd == r) return 1;
    if (mp[2].v && mp[2].rw && mp[2].rd == r) return 2;
    return 0;
  endfunction

  function automatic bit m_hazard(instr_t c);
    if (!c.v || !mp[0].v || !mp[0].mr || !mp[0].rw || mp[0].rd == ZREG) return 0;
    return (c.urn && c.rn == mp[0].rd) || (c.urm && c.rm == mp[0].rd);
  endfunction

  function automatic bit m_stall(instr_t c, bit fl);
    return !fl && (m_left > 0 || m_hazard(c));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) mp[k] = mk_i(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_left = 0;
    m_perf = 0;
  endtask

  task automatic model_step(instr_t c, bit fl);
    bit st, hz;
    st = m_stall(c, fl);
    hz = m_hazard(c);
    mp[2] = mp[1];
    mp[1] = mp[0];
    mp[0] = (st || fl || !c.v) ? mk_i(0, 0, 0, 0, 0, 0, 0, 0, 0, 0) : c;
    if (fl)              m_left = 0;
    else if (m_left > 0) m_left--;
    else if (hz)         m_left = LS - 1;
    if (st) m_perf++;
  endtask

  task automatic chk(string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic apply(instr_t i, bit fl);
    hif.id_valid    = i.v;
    hif.id_rn       = 5'(i.rn);
    hif.id_rm       = 5'(i.rm);
    hif.id_use_rn   = i.urn;
    hif.id_use_rm   = i.urm;
    hif.id_rd       = 5'(i.rd);
    hif.id_regwrite = i.rw;
    hif.id_memread  = i.mr;
    hif.id_setflags = i.sf;
    hif.id_bcond    = i.bc;
    hif.flush       = fl;
  endtask

  task automatic chk_out(string tag, int fa, int fb, bit st, bit ff);
    chk({tag, ".fwdA"}, 32'(hif.forwardA), 32'(fa));
    chk({tag, ".fwdB"}, 32'(hif.forwardB), 32'(fb));
    chk({tag, ".stall"}, 32'(hif.stall), 32'(st));
    chk({tag, ".flag_fwd"}, 32'(hif.flag_fwd), 32'(ff));
  endtask

  initial begin
    vec_t   vt[32];
    instr_t nop, c;
    int     regs[4];
    bit     fl;
    regs = '{1, 2, 3, 31};
    nop = mk_i(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //          v rn rm un um rd rw mr sf bc fl  fa fb st ff
    vt[0]  = mk(1, 5, 6, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); // ADD X1
    vt[1]  = mk(1, 1, 8, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0); // reads X1
    vt[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); // X1 in MEM
    vt[3]  = mk(1, 9, 9, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0); // X2 (older)
    vt[4]  = mk(1,10,10, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0); // X2 (newer)
    vt[5]  = mk(1, 2, 2, 1, 1,11, 1, 0, 0, 0, 0, 0, 0, 0, 0); // reads X2,X2
    vt[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0); // MEM beats WB
    vt[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[8]  = mk(1,13,13, 1, 1,12, 1, 0, 0, 0, 0, 0, 0, 0, 0); // X12
    vt[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[10] = mk(1, 0,12, 1, 1,14, 1, 0, 0, 0, 0, 0, 0, 0, 0); // reads X12 as rm
    vt[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0); // WB forward on B
    vt[12] = mk(1, 4, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0); // LDUR X3
    vt[13] = mk(1, 3,16, 1, 1,15, 1, 0, 0, 0, 0, 0, 0, 1, 0); // load-use
    vt[14] = mk(1, 3,16, 1, 1,15, 1, 0, 0, 0, 0, 0, 0, 1, 0); // second stall cycle
    vt[15] = mk(1, 3,16, 1, 1,15, 1, 0, 0, 0, 0, 0, 0, 0, 0); // released
    vt[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // load already retired
    vt[17] = mk(1, 1, 1, 1, 1,31, 1, 0, 0, 0, 0, 0, 0, 0, 0); // dest X31
    vt[18] = mk(1,31,31, 1, 1,20, 1, 0, 0, 0, 0, 0, 0, 0, 0); // reads X31
    vt[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // X31 never forwards
    vt[20] = mk(1, 2, 0, 1, 0,31, 1, 1, 0, 0, 0, 0, 0, 0, 0); // LDUR X31
    vt[21] = mk(1,31, 5, 1, 1,21, 1, 0, 0, 0, 0, 0, 0, 0, 0); // no stall on X31
    vt[22] = mk(1, 6, 0, 1, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0); // LDUR X4
    vt[23] = mk(1, 4, 4, 1, 1,22, 1, 0, 0, 0, 1, 0, 0, 0, 0); // flush beats hazard
    vt[24] = mk(1, 4, 4, 1, 1,23, 1, 0, 0, 0, 0, 0, 0, 0, 0); // EX squashed
    vt[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0); // load in WB forwards
    vt[26] = mk(1, 1, 2, 1, 1,24, 1, 0, 1, 0, 0, 0, 0, 0, 0); // SUBS
    vt[27] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1); // B.cond after SUBS
    vt[28] = mk(1, 1, 2, 1, 1,25, 1, 0, 0, 0, 0, 0, 0, 0, 0); // ADD
    vt[29] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0); // B.cond after ADD
    vt[30] = mk(1, 1, 2, 1, 1,26, 1, 0, 1, 0, 0, 0, 0, 0, 0); // SUBS
    vt[31] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0); // invalid ID: no flag_fwd

    // Reset state with a busy-looking ID stage
    apply(mk_i(1, 3, 3, 1, 1, 3, 1, 1, 1, 1), 0);
    #1;
    chk_out("reset", 0, 0, 0, 0);
`ifdef HAZARD_PERF_EN
    chk("reset.stall_count", 32'(hif.stall_count), 0);
`endif
    @(negedge clk);
    apply(nop, 0);
    reset = 1'b0;

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      apply(vt[i].in, vt[i].fl);
      #1;
      chk_out($sformatf("vec%0d", i), vt[i].fa, vt[i].fb, vt[i].st, vt[i].ff);
    end

    // Reset in the middle of a load-use stall
    @(negedge clk);
`ifdef HAZARD_PERF_EN
    chk("table.stall_count", 32'(hif.stall_count), 2);
`endif
    apply(mk_i(1, 4, 0, 1, 0, 3, 1, 1, 0, 0), 0);
    @(negedge clk);
    apply(mk_i(1, 3, 0, 1, 0, 9, 1, 0, 0, 1), 0);
    #1;
    chk("midrst.pre_stall", 32'(hif.stall), 1);
    @(negedge clk);
    #1;
    chk("midrst.stall_held", 32'(hif.stall), 1);
    #2;
    reset = 1'b1;
    #1;
    chk_out("midrst", 0, 0, 0, 0);
`ifdef HAZARD_PERF_EN
    chk("midrst.stall_count", 32'(hif.stall_count), 0);
`endif
    @(negedge clk);
    apply(nop, 0);
    reset = 1'b0;
    model_reset();

    // Random traffic on a small register set so dependences are frequent
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      c.v   = ($urandom_range(0, 9) != 0);
      c.rn  = regs[$urandom_range(0, 3)];
      c.rm  = regs[$urandom_range(0, 3)];
      c.rd  = regs[$urandom_range(0, 3)];
      c.urn = 1'($urandom_range(0, 1));
      c.urm = 1'($urandom_range(0, 1));
      c.rw  = ($urandom_range(0, 3) != 0);
      c.mr  = c.rw && ($urandom_range(0, 2) == 0);
      c.sf  = 1'($urandom_range(0, 1));
      c.bc  = ($urandom_range(0, 3) == 0);
      fl    = ($urandom_range(0, 9) == 0);
      apply(c, fl);
      #1;
      chk_out($sformatf("rnd%0d", n), m_fwd(mp[0].urn, mp[0].rn), m_fwd(mp[0].urm, mp[0].rm),
              m_stall(c, fl), c.v && c.bc && mp[0].v && mp[0].sf);
      model_step(c, fl);
    end
    @(negedge clk);
`ifdef HAZARD_PERF_EN
    chk("rnd.stall_count", 32'(hif.stall_count), 32'(m_perf));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
